// File: rtl/mips_multicycle_ctrl.sv
// Moore main-control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/write-back.
// Optional feature macro ZEXT_IMM_EN: andi/ori become legal and select the zero-filling immediate extender.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_zero,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       in_fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t state_q;
    state_t state_nxt;
    ctrl_t  ctrl_q;

    // Datapath gates pc_write_cond with the ALU zero flag, so it is not needed here.
    logic unused_zero;
    assign unused_zero = zero;

    function automatic state_t decode_target(input logic [5:0] op);
        state_t t;
        case (op)
            OP_LW, OP_SW:     t = MEM_ADDR;
            OP_RTYPE:         t = EXEC_R;
            OP_ADDI, OP_SLTI: t = EXEC_I;
`ifdef ZEXT_IMM_EN
            OP_ANDI, OP_ORI:  t = EXEC_I;
`endif
            OP_BEQ:           t = BRANCH;
            OP_J:             t = JUMP;
            default:          t = HALT;
        endcase
        return t;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                          input logic ready);
        state_t n;
        case (s)
            FETCH:    n = ready ? DECODE : FETCH;
            DECODE:   n = decode_target(op);
            MEM_ADDR: n = (op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   n = ready ? MEM_WB : MEM_RD;
            MEM_WR:   n = ready ? FETCH : MEM_WR;
            EXEC_R:   n = R_WB;
            EXEC_I:   n = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: n = FETCH;
            HALT:     n = HALT;
            default:  n = HALT;
        endcase
        return n;
    endfunction

    // Per-state control word; FETCH's pc_write/ir_write are added combinationally from mem_ready.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.in_fetch  = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE:   c.alu_src_b = 2'b11;
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
            end
            I_WB:     c.reg_write = 1'b1;
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = next_state(state_q, opcode, mem_ready);
    end

`ifdef ZEXT_IMM_EN
    logic ext_zero_q;

    // Control word is registered from the next state so outputs come straight off flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            ctrl_q     <= ctrl_for(FETCH);
            illegal    <= 1'b0;
            ext_zero_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= ctrl_for(state_nxt);
            if (state_nxt == HALT)
                illegal <= 1'b1;
            if (state_q == DECODE)
                ext_zero_q <= (opcode == OP_ANDI) || (opcode == OP_ORI);
        end
    end

    assign ext_zero = ext_zero_q;
`else
    // Control word is registered from the next state so outputs come straight off flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_for(FETCH);
            illegal <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= ctrl_for(state_nxt);
            if (state_nxt == HALT)
                illegal <= 1'b1;
        end
    end

    assign ext_zero = 1'b0;
`endif

    assign pc_write      = ctrl_q.pc_write | (ctrl_q.in_fetch & mem_ready);
    assign ir_write      = ctrl_q.in_fetch & mem_ready;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign iord          = ctrl_q.iord;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign pc_source     = ctrl_q.pc_source;
    assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: each instruction is expanded into its expected
// per-cycle state/handshake schedule and every cycle is compared against the control table.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       ext_zero, illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    bit ez_exp = 1'b0;
    bit ill_exp = 1'b0;

`ifdef ZEXT_IMM_EN
    localparam bit ZEXT = 1'b1;
`else
    localparam bit ZEXT = 1'b0;
`endif

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .ext_zero(ext_zero), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control table indexed by state code: {pcw,pcwc,irw,mrd,mwr,iord,rw,rdst,m2r,srca,srcb,aluop,pcsrc}
    function automatic logic [15:0] expCtrl(input int s, input bit mr);
        logic pcw, pcwc, irw, mrd, mwr, io, rw, rd, m2r, sa;
        logic [1:0] sb, ao, ps;
        {pcw, pcwc, irw, mrd, mwr, io, rw, rd, m2r, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            0:  begin mrd = 1; sb = 2'b01; pcw = mr; irw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; sb = 2'b10; ao = 2'b11; end
            9:  rw = 1;
            10: begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
            11: begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, irw, mrd, mwr, io, rw, rd, m2r, sa, sb, ao, ps};
    endfunction

    // One clock cycle: drive inputs, compare against the expected state, then advance.
    task automatic applyStimulus(input logic [5:0] op, input bit rdy, input bit rst,
                                 input bit z, input int exp_state, input bit new_ez);
        opcode = op; mem_ready = rdy; reset = rst; zero = z;
        #1;
        if (exp_state == 15) ill_exp = 1'b1;
        checkOutput("state", {28'd0, state}, exp_state);
        checkOutput("ctrl", {16'd0, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                             iord, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                             alu_op, pc_source}, {16'd0, expCtrl(exp_state, rdy)});
        checkOutput("ext_zero", {31'd0, ext_zero}, {31'd0, ez_exp});
        checkOutput("illegal", {31'd0, illegal}, {31'd0, ill_exp});
        if (exp_state == 1) ez_exp = new_ez;
        if (rst) begin
            ez_exp = 1'b0;
            ill_exp = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Expands one instruction into its cycle schedule from the opcode classification.
    task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input bit z,
                            input bit rst_mid, input int halt_len);
        bit is_mem, is_r, is_i, is_beq, is_j, is_zx, new_ez;
        is_zx  = ZEXT && (op == 6'b001100 || op == 6'b001101);
        is_mem = (op == 6'b100011) || (op == 6'b101011);
        is_r   = (op == 6'b000000);
        is_i   = (op == 6'b001000) || (op == 6'b001010) || is_zx;
        is_beq = (op == 6'b000100);
        is_j   = (op == 6'b000010);
        new_ez = is_zx;
        for (int k = 0; k < fw; k++) applyStimulus(op, 1'b0, 1'b0, z, 0, 1'b0);
        applyStimulus(op, 1'b1, 1'b0, z, 0, 1'b0);
        applyStimulus(op, 1'($urandom), 1'b0, z, 1, new_ez);
        if (is_mem) begin
            applyStimulus(op, 1'($urandom), 1'b0, z, 2, 1'b0);
            if (op == 6'b100011) begin
                if (rst_mid) begin
                    applyStimulus(op, 1'b0, 1'b1, z, 3, 1'b0);
                    return;
                end
                for (int k = 0; k < mw; k++) applyStimulus(op, 1'b0, 1'b0, z, 3, 1'b0);
                applyStimulus(op, 1'b1, 1'b0, z, 3, 1'b0);
                applyStimulus(op, 1'($urandom), 1'b0, z, 4, 1'b0);
            end else begin
                if (rst_mid) begin
                    applyStimulus(op, 1'b0, 1'b1, z, 5, 1'b0);
                    return;
                end
                for (int k = 0; k < mw; k++) applyStimulus(op, 1'b0, 1'b0, z, 5, 1'b0);
                applyStimulus(op, 1'b1, 1'b0, z, 5, 1'b0);
            end
        end else if (is_r) begin
            applyStimulus(op, 1'($urandom), 1'b0, z, 6, 1'b0);
            applyStimulus(op, 1'($urandom), 1'b0, z, 7, 1'b0);
        end else if (is_i) begin
            applyStimulus(op, 1'($urandom), 1'b0, z, 8, 1'b0);
            applyStimulus(op, 1'($urandom), 1'b0, z, 9, 1'b0);
        end else if (is_beq) begin
            applyStimulus(op, 1'($urandom), 1'b0, z, 10, 1'b0);
        end else if (is_j) begin
            applyStimulus(op, 1'($urandom), 1'b0, z, 11, 1'b0);
        end else begin
            for (int k = 0; k < halt_len - 1; k++)
                applyStimulus(op, 1'($urandom), 1'b0, z, 15, 1'b0);
            applyStimulus(op, 1'($urandom), 1'b1, z, 15, 1'b0);
        end
    endtask

    logic [5:0] op_table [9];

    initial begin
        op_table = '{6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
                     6'b100011, 6'b101011, 6'b000100, 6'b000010};
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0; zero = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        $display("[TB] reset released, starting directed sequence");
        runInstr(6'b100011, 0, 0, 1'b0, 1'b0, 0);
        runInstr(6'b101011, 0, 3, 1'b0, 1'b0, 0);
        runInstr(6'b001101, 0, 0, 1'b0, 1'b0, 10);
        runInstr(6'b000000, 1, 0, 1'b0, 1'b0, 0);
        runInstr(6'b000100, 0, 0, 1'b1, 1'b0, 0);
        runInstr(6'b000010, 0, 0, 1'b0, 1'b0, 0);
        runInstr(6'b001100, 2, 0, 1'b0, 1'b0, 10);
        runInstr(6'b001000, 0, 0, 1'b0, 1'b0, 0);
        runInstr(6'b111111, 0, 0, 1'b0, 1'b0, 10);
        runInstr(6'b100011, 0, 0, 1'b0, 1'b1, 0);
        runInstr(6'b101011, 1, 0, 1'b0, 1'b1, 0);
        $display("[TB] starting random sequence");
        for (int n = 0; n < 120; n++) begin
            logic [5:0] op;
            int idx;
            idx = $urandom_range(0, 9);
            op = (idx == 9) ? 6'($urandom) : op_table[idx];
            runInstr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom),
                     ($urandom_range(0, 7) == 0), $urandom_range(1, 6));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back. It drives every datapath select, including the immediate extender mode (zero vs sign) that feeds ALU operand B. It waits on a memory ready handshake and traps unsupported opcodes into a sticky halt.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising clk edge
- opcode  input  6  IR[31:26]; valid from the cycle after a completed fetch
- zero  input  1  ALU zero flag, used in BRANCH
- mem_ready  input  1  memory handshake; the access completes in the cycle it is 1
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath enables and selects
- alu_src_b  output  2  00 reg B, 01 const 4, 10 extended imm, 11 extended imm<<2
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded (immediate ops)
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
- ext_zero  output  1  1: extender zero-fills imm; 0: extender sign-extends imm
- illegal  output  1  sticky; unsupported opcode was decoded
- state  output  4  current state code, for debug and verification

## Operation
- Supported opcodes:
  - R-type 000000
  - addi 001000
  - slti 001010
  - andi 001100
  - ori 001101
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11, HALT 15.
- Transitions:
  - FETCH->DECODE when mem_ready=1, else stay in FETCH.
  - DECODE by opcode:
    - lw/sw -> MEM_ADDR
    - R-type -> EXEC_R
    - addi/slti/andi/ori -> EXEC_I
    - beq -> BRANCH
    - j -> JUMP
    - anything else -> HALT
  - MEM_ADDR -> MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD -> MEM_WB when mem_ready=1, else stay in MEM_RD.
  - MEM_WR -> FETCH when mem_ready=1, else stay in MEM_WR.
  - EXEC_R -> R_WB; EXEC_I -> I_WB.
  - MEM_WB, R_WB, I_WB, BRANCH and JUMP -> FETCH.
  - HALT stays in HALT until reset.
- Outputs are a function of state only, except pc_write and ir_write in FETCH, which equal mem_ready. Any signal not listed below is 0.
  - FETCH: mem_read=1, alu_src_b=01, pc_write=ir_write=mem_ready.
  - DECODE: alu_src_b=11 (branch target precompute).
  - MEM_ADDR: alu_src_a=1, alu_src_b=10.
  - MEM_RD: mem_read=1, iord=1.
  - MEM_WB: reg_write=1, mem_to_reg=1.
  - MEM_WR: mem_write=1, iord=1.
  - EXEC_R: alu_src_a=1, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11.
  - I_WB: reg_write=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. The datapath gates pc_write_cond with zero.
  - JUMP: pc_write=1, pc_source=10.
  - HALT: all 0.
- ext_zero is registered. It is loaded only in DECODE (1 for andi/ori, 0 for all other opcodes) and held until the next DECODE.
- illegal is set on entry to HALT and held until reset.

## Timing
- Reset: state=FETCH, ext_zero=0, illegal=0.
  - All outputs take their FETCH values. pc_write and ir_write follow mem_ready.
- Reset asserted in any state, including mid-wait in MEM_RD/MEM_WR or in HALT, returns to FETCH on that edge. No write enable is asserted in the cycle after that edge except the FETCH enables.
- Latency in cycles, with zero-wait memory (mem_ready=1):
  - lw 5
  - sw 4
  - R-type and I-type 4
  - beq 3
  - j 3
- Each cycle mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. mem_read/mem_write stay asserted and the outputs stay stable while waiting.
- mem_ready is ignored in every other state.
- ext_zero changes only on the edge leaving DECODE. It is therefore stable for MEM_ADDR, EXEC_I and BRANCH.

## Configuration
- ZEXT_IMM_EN defined:
  - andi/ori decode to EXEC_I with ext_zero=1.
- ZEXT_IMM_EN undefined:
  - andi and ori are unsupported and decode to HALT with illegal=1.
  - ext_zero is tied to 0 and never leaves its reset value.
  - addi and slti are unaffected.

## Test plan
- Reset for 2 cycles, then release with mem_ready=1 and opcode=100011 (lw):
  - state sequence 0,1,2,3,4,0
  - reg_write=1 and mem_to_reg=1 only in state 4
- sw with mem_ready=0 for 3 cycles in MEM_WR:
  - state 5 held 4 cycles with mem_write=1 throughout
  - return to 0 after mem_ready=1
- ori (001101) with ZEXT_IMM_EN defined:
  - ext_zero=1 from state 8 through the next DECODE
- Same stimulus with ZEXT_IMM_EN undefined:
  - state=15, illegal=1, all enables 0
  - remains in HALT for 10 cycles; reset returns state=0, illegal=0
- beq with zero=1, then j:
  - beq: pc_write_cond=1, pc_source=01 in state 10
  - j: pc_write=1, pc_source=10 in state 11
  - each instruction takes 3 cycles
- reset=1 while state=3 and mem_ready=0:
  - next cycle state=0, mem_read=1, iord=0, reg_write=0
